direction_controller: RTL

- Converts four raw push-buttons into the 2-bit `direction` consumed by the snake game logic.
- Synchronizes and debounces each button, detects presses, and rejects 180° reversals.
- Commits at most one turn per game step, on `update_tick`.
- Runs entirely in the `vga_clk` domain; the game-step strobe arrives as a single-cycle pulse.

---
 rtl/direction_controller_pkg.sv | 29 ++
 rtl/button_debounce.sv | 48 ++++
 rtl/direction_controller.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/direction_controller_pkg.sv
// Shared direction codes, debounce default and press-priority helper for direction_controller.
`ifndef DIRECTION_CONTROLLER_DEFINES
`define DIRECTION_CONTROLLER_DEFINES
`define LEFT_DIR  2'd0
`define TOP_DIR   2'd1
`define RIGHT_DIR 2'd2
`define DOWN_DIR  2'd3
// LEFT<->RIGHT and TOP<->DOWN differ only in bit 1 with this encoding.
`define DIR_OPPOSITE(d) ((d) ^ 2'd2)
`define DEBOUNCE_CYCLES_DEFAULT 250000
`endif

package direction_controller_pkg;

    localparam int unsigned NUM_BTN = 4;

    // Press vector is {up, down, left, right}; highest bit wins.
    function automatic logic [1:0] press_priority(input logic [NUM_BTN-1:0] p);
        if (p[3]) begin
            return `TOP_DIR;
        end else if (p[2]) begin
            return `DOWN_DIR;
        end else if (p[1]) begin
            return `LEFT_DIR;
        end
        return `RIGHT_DIR;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One push-button: 2-FF synchronizer, stable-count debouncer and registered rising-edge pulse.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = `DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = 18
) (
    input  logic vga_clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q;

    // Any cycle where the synced input agrees with the level restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_raw};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= level_d & ~level_q;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/direction_controller.sv
// Button-to-heading controller for the snake game; commits at most one turn per update_tick.
// Define DIR_QUEUE2_EN to buffer up to two pending turns instead of one.
module direction_controller
    import direction_controller_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = `DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = 18,
    parameter logic [1:0]  RESET_DIR       = `RIGHT_DIR
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       update_tick,
    input  logic       game_over,
    output logic [0:1] direction,
    output logic       pending_valid,
    output logic       turn_rejected
);

    logic [NUM_BTN-1:0] press;
    logic [1:0]         sel_dir, ref_dir;
    logic               press_any;
    logic [1:0]         dir_q, dir_d;
    logic               rej_q, rej_d;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_up (
        .vga_clk(vga_clk), .reset(reset), .btn_raw(btn_up), .press(press[3])
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_down (
        .vga_clk(vga_clk), .reset(reset), .btn_raw(btn_down), .press(press[2])
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_left (
        .vga_clk(vga_clk), .reset(reset), .btn_raw(btn_left), .press(press[1])
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_right (
        .vga_clk(vga_clk), .reset(reset), .btn_raw(btn_right), .press(press[0])
    );

    assign press_any = |press;
    assign sel_dir   = press_priority(press);

`ifdef DIR_QUEUE2_EN
    logic [1:0] fifo_q [2];
    logic [1:0] fifo_d [2];
    logic [1:0] fcnt_q, fcnt_d;

    // Reference is the newest queued turn (tail), or the live heading when empty.
    assign ref_dir = (fcnt_q == 2'd0) ? dir_q : fifo_q[fcnt_q[1]];

    always_comb begin
        dir_d     = dir_q;
        rej_d     = 1'b0;
        fifo_d[0] = fifo_q[0];
        fifo_d[1] = fifo_q[1];
        fcnt_d    = fcnt_q;
        if (game_over) begin
            fcnt_d = 2'd0;
        end else begin
            if (update_tick && (fcnt_q != 2'd0)) begin
                dir_d     = fifo_q[0];
                fifo_d[0] = fifo_q[1];
                fcnt_d    = fcnt_q - 2'd1;
            end
            if (press_any) begin
                if ((sel_dir == ref_dir) || (sel_dir == `DIR_OPPOSITE(ref_dir))) begin
                    rej_d = 1'b1;
                end else if (fcnt_d == 2'd2) begin
                    fifo_d[1] = sel_dir;
                end else begin
                    fifo_d[fcnt_d[0]] = sel_dir;
                    fcnt_d            = fcnt_d + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            fifo_q[0] <= RESET_DIR;
            fifo_q[1] <= RESET_DIR;
            fcnt_q    <= 2'd0;
        end else begin
            fifo_q[0] <= fifo_d[0];
            fifo_q[1] <= fifo_d[1];
            fcnt_q    <= fcnt_d;
        end
    end

    assign pending_valid = (fcnt_q != 2'd0);
`else
    logic [1:0] pend_dir_q, pend_dir_d;
    logic       pend_valid_q, pend_valid_d;

    // When a tick commits, the pending turn is also the heading being committed.
    assign ref_dir = pend_valid_q ? pend_dir_q : dir_q;

    always_comb begin
        dir_d        = dir_q;
        rej_d        = 1'b0;
        pend_dir_d   = pend_dir_q;
        pend_valid_d = pend_valid_q;
        if (game_over) begin
            pend_valid_d = 1'b0;
        end else begin
            if (update_tick && pend_valid_q) begin
                dir_d        = pend_dir_q;
                pend_valid_d = 1'b0;
            end
            if (press_any) begin
                if ((sel_dir == ref_dir) || (sel_dir == `DIR_OPPOSITE(ref_dir))) begin
                    rej_d = 1'b1;
                end else begin
                    pend_dir_d   = sel_dir;
                    pend_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            pend_dir_q   <= RESET_DIR;
            pend_valid_q <= 1'b0;
        end else begin
            pend_dir_q   <= pend_dir_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    assign pending_valid = pend_valid_q;
`endif

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            dir_q <= RESET_DIR;
            rej_q <= 1'b0;
        end else begin
            dir_q <= dir_d;
            rej_q <= rej_d;
        end
    end

    assign direction     = dir_q;
    assign turn_rejected = rej_q;

endmodule
